memory_16bit_arbiter: RTL and testbench
=======================================

Name: memory_16bit_arbiter

Overview:
- Two-port arbiter/sequencer that shares the 2-entry x 16-bit register memory (`memory_16bit`) between requester A and requester B.
- Accepts one read or write per transaction and picks a winner round-robin, or fixed priority when configured.
- Drives the memory's sel/write/dataIn and captures dataOut.
- Sits between the memory instance and two client blocks, so neither client ever touches the memory ports directly.

Parameters:
- FIXED_PRIO, 0, 0 = round-robin between A and B; 1 = A always wins a simultaneous request.

Ports:
- clk  input  1  system clock, all logic on posedge
- rst_n  input  1  synchronous active-low reset
- reqA  input  1  requester A transaction request (level)
- weA  input  1  A: 1 = write, 0 = read
- selA  input  1  A: target register (0 = reg0, 1 = reg1)
- wdataA  input  16  A write data
- gntA  output  1  one-cycle pulse: A's request captured
- doneA  output  1  one-cycle pulse: A's transaction complete
- rdataA  output  16  A read data, valid while doneA = 1
- reqB, weB, selB, wdataB, gntB, doneB, rdataB  same as A, for requester B
- memSel  output  1  to memory sel
- memWrite  output  1  to memory write
- memDataIn  output  16  to memory dataIn
- memDataOut  input  16  from memory dataOut (combinational read of memSel)

Behaviour:
- One clock domain. Reset is synchronous and active-low (`rst_n` sampled on posedge `clk`). All state and outputs are registered.
- Reset values:
  - state = IDLE
  - gntA/gntB/doneA/doneB = 0
  - rdataA/rdataB = 0
  - memSel = 0, memWrite = 0, memDataIn = 0
  - rrLast = B, so A wins the first tie.
- FSM states: IDLE -> ACCESS -> DONE -> IDLE. A fixed 3-cycle transaction gives max throughput of 1 transaction per 3 cycles.
- IDLE:
  - Sample reqA/reqB.
  - None asserted: stay in IDLE, memWrite = 0, memSel holds its last value.
  - Exactly one asserted: that port wins.
  - Both asserted:
    - FIXED_PRIO = 1: A wins.
    - FIXED_PRIO = 0: the port that is not rrLast wins.
  - On a win: latch owner, we, sel, wdata; go to ACCESS. In the same edge, load memSel = sel, memWrite = we, memDataIn = wdata, and gnt<owner> = 1.
- ACCESS (1 cycle):
  - Memory sees the registered memSel/memWrite/memDataIn.
  - Write: commits at the end-of-ACCESS edge.
  - Read: memDataOut is captured into rdata<owner> at the same edge.
  - At that edge: gnt drops; memWrite <= 0; rrLast <= owner; done<owner> <= 1; go to DONE.
- DONE (1 cycle):
  - done<owner> = 1 and rdata<owner> is valid. For a write, rdata<owner> holds the written data, with done as the completion marker.
  - Next edge: done <= 0, go to IDLE.
  - rdata holds its value until that port's next read/write completes.
- Requester rules:
  - Hold req, we, sel, wdata stable until gnt is seen.
  - Deassert req in the cycle after gnt unless a new request is intended.
  - Any req still high when the FSM re-enters IDLE is a new request.
  - The loser keeps req high and wins the next IDLE arbitration (round-robin). Under FIXED_PRIO = 1, B can starve.
- Requests during ACCESS/DONE are ignored; they are only sampled in IDLE.
- memWrite is high only in ACCESS and only for write transactions; it is never high for two consecutive cycles.
- Ordering: a read issued after a write to the same register returns the new data.
- Reset mid-operation:
  - rst_n low at any edge forces all reset values at that edge. No gnt/done pulse follows.
  - A write whose ACCESS cycle coincides with the reset edge still commits in the memory, because memWrite was high in that cycle.
  - The memory contents themselves are not cleared.
- gntA and gntB are never high together, and neither are doneA and doneB.

Test Plan:
- Reset then single writes: A write sel=0 0xA5A5, then B write sel=1 0x3C3C -> gntA at cycle 1, doneA at cycle 2; the same pattern for B; memWrite high exactly 1 cycle each.
- Read-back: A read sel=0, then B read sel=1 -> rdataA = 0xA5A5 with doneA; rdataB = 0x3C3C with doneB; memWrite stays 0.
- Simultaneous requests, FIXED_PRIO = 0: reqA = reqB = 1 held for 4 transactions -> grant order A, B, A, B, with gnt pulses 3 cycles apart.
- FIXED_PRIO = 1, both held -> A granted every transaction, B never granted. Drop reqA -> B granted at the next IDLE.
- Write/read hazard: B write sel=1 0xFFFF, then A read sel=1 -> rdataA = 0xFFFF.
- Reset during ACCESS of A write sel=0 0x1234 -> no doneA; all outputs 0 the next cycle. A subsequent read of sel=0 returns 0x1234.

Source files
------------

// File: rtl/memory_16bit_arbiter.sv
// Two-requester arbiter/sequencer for the 2 x 16-bit register memory.
// Each transaction takes IDLE -> ACCESS -> DONE, so one completes every three cycles.
// Ties go round-robin, or always to A when FIXED_PRIO is set.
module memory_16bit_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reqA,
    input  logic        weA,
    input  logic        selA,
    input  logic [15:0] wdataA,
    output logic        gntA,
    output logic        doneA,
    output logic [15:0] rdataA,
    input  logic        reqB,
    input  logic        weB,
    input  logic        selB,
    input  logic [15:0] wdataB,
    output logic        gntB,
    output logic        doneB,
    output logic [15:0] rdataB,
    output logic        memSel,
    output logic        memWrite,
    output logic [15:0] memDataIn,
    input  logic [15:0] memDataOut
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        rr_last_q, rr_last_d;
    logic        mem_sel_q, mem_sel_d;
    logic        mem_write_q, mem_write_d;
    logic [15:0] mem_data_in_q, mem_data_in_d;
    logic        gnt_a_q, gnt_a_d;
    logic        gnt_b_q, gnt_b_d;
    logic        done_a_q, done_a_d;
    logic        done_b_q, done_b_d;
    logic [15:0] rdata_a_q, rdata_a_d;
    logic [15:0] rdata_b_q, rdata_b_d;
    logic        pick_b_s;

    // Arbitration: decide whether B wins the current IDLE sample.
    always_comb begin
        pick_b_s = 1'b0;
        if (reqA && reqB) begin
            if (FIXED_PRIO) begin
                pick_b_s = 1'b0;
            end else begin
                pick_b_s = (rr_last_q == PORT_A);
            end
        end else begin
            pick_b_s = reqB;
        end
    end

    // Next-state and registered-output computation for the transaction sequencer.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_last_d     = rr_last_q;
        mem_sel_d     = mem_sel_q;
        mem_write_d   = 1'b0;
        mem_data_in_d = mem_data_in_q;
        gnt_a_d       = 1'b0;
        gnt_b_d       = 1'b0;
        done_a_d      = 1'b0;
        done_b_d      = 1'b0;
        rdata_a_d     = rdata_a_q;
        rdata_b_d     = rdata_b_q;
        case (state_q)
            ST_IDLE: begin
                if (reqA || reqB) begin
                    owner_d = pick_b_s;
                    state_d = ST_ACCESS;
                    if (pick_b_s) begin
                        mem_sel_d     = selB;
                        mem_write_d   = weB;
                        mem_data_in_d = wdataB;
                        gnt_b_d       = 1'b1;
                    end else begin
                        mem_sel_d     = selA;
                        mem_write_d   = weA;
                        mem_data_in_d = wdataA;
                        gnt_a_d       = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                // A write reports the data it stored; a read captures the memory output.
                rr_last_d = owner_q;
                state_d   = ST_DONE;
                if (owner_q == PORT_B) begin
                    done_b_d  = 1'b1;
                    rdata_b_d = mem_write_q ? mem_data_in_q : memDataOut;
                end else begin
                    done_a_d  = 1'b1;
                    rdata_a_d = mem_write_q ? mem_data_in_q : memDataOut;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            owner_q       <= PORT_A;
            rr_last_q     <= PORT_B;
            mem_sel_q     <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_data_in_q <= 16'h0000;
            gnt_a_q       <= 1'b0;
            gnt_b_q       <= 1'b0;
            done_a_q      <= 1'b0;
            done_b_q      <= 1'b0;
            rdata_a_q     <= 16'h0000;
            rdata_b_q     <= 16'h0000;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            rr_last_q     <= rr_last_d;
            mem_sel_q     <= mem_sel_d;
            mem_write_q   <= mem_write_d;
            mem_data_in_q <= mem_data_in_d;
            gnt_a_q       <= gnt_a_d;
            gnt_b_q       <= gnt_b_d;
            done_a_q      <= done_a_d;
            done_b_q      <= done_b_d;
            rdata_a_q     <= rdata_a_d;
            rdata_b_q     <= rdata_b_d;
        end
    end

    assign gntA      = gnt_a_q;
    assign gntB      = gnt_b_q;
    assign doneA     = done_a_q;
    assign doneB     = done_b_q;
    assign rdataA    = rdata_a_q;
    assign rdataB    = rdata_b_q;
    assign memSel    = mem_sel_q;
    assign memWrite  = mem_write_q;
    assign memDataIn = mem_data_in_q;

endmodule

// File: tb/tb_memory_16bit_arbiter.sv
// Directed bench: two arbiter instances (round-robin and fixed priority) share stimulus,
// each attached to its own behavioural 2 x 16-bit register memory.
module tb_memory_16bit_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_a, we_a, sel_a, req_b, we_b, sel_b;
    logic [15:0] wdata_a, wdata_b;
    logic [1:0]  gnt_a, gnt_b, done_a, done_b, mem_sel, mem_write;
    logic [15:0] rdata_a [2];
    logic [15:0] rdata_b [2];
    logic [15:0] mem_din [2];
    logic [15:0] mem_dout [2];

    int nvec = 0;
    int nerr = 0;

    // Values observed by run_single for each instance.
    logic [1:0]  obs_gnt [2];
    logic [1:0]  obs_done [2];
    logic [1:0]  obs_after [2];
    logic        obs_sel [2];
    logic [15:0] obs_rdata [2];
    int          obs_mw [2];

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_dut
            logic [15:0] mem [2];
            memory_16bit_arbiter #(.FIXED_PRIO(g == 1)) u_dut (
                .clk(clk), .rst_n(rst_n),
                .reqA(req_a), .weA(we_a), .selA(sel_a), .wdataA(wdata_a),
                .gntA(gnt_a[g]), .doneA(done_a[g]), .rdataA(rdata_a[g]),
                .reqB(req_b), .weB(we_b), .selB(sel_b), .wdataB(wdata_b),
                .gntB(gnt_b[g]), .doneB(done_b[g]), .rdataB(rdata_b[g]),
                .memSel(mem_sel[g]), .memWrite(mem_write[g]),
                .memDataIn(mem_din[g]), .memDataOut(mem_dout[g])
            );
            assign mem_dout[g] = mem[mem_sel[g]];
            always @(posedge clk) begin
                if (mem_write[g]) mem[mem_sel[g]] <= mem_din[g];
            end
        end
    endgenerate

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one request from port (0 = A, 1 = B) and record what both instances show.
    task automatic run_single(input int port, input logic we, input logic sel, input logic [15:0] data);
        if (port == 0) begin
            req_a = 1'b1; we_a = we; sel_a = sel; wdata_a = data;
        end else begin
            req_b = 1'b1; we_b = we; sel_b = sel; wdata_b = data;
        end
        tick();
        for (int d = 0; d < 2; d++) begin
            obs_gnt[d] = {gnt_b[d], gnt_a[d]};
            obs_sel[d] = mem_sel[d];
            obs_mw[d]  = int'(mem_write[d]);
        end
        req_a = 1'b0; req_b = 1'b0;
        tick();
        for (int d = 0; d < 2; d++) begin
            obs_done[d]  = {done_b[d], done_a[d]};
            obs_rdata[d] = (port == 0) ? rdata_a[d] : rdata_b[d];
            obs_mw[d]    = obs_mw[d] + int'(mem_write[d]);
        end
        tick();
        for (int d = 0; d < 2; d++) begin
            obs_after[d] = {done_b[d], done_a[d]};
            obs_mw[d]    = obs_mw[d] + int'(mem_write[d]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_a = 1'b0; we_a = 1'b0; sel_a = 1'b0; wdata_a = 16'h0000;
        req_b = 1'b0; we_b = 1'b0; sel_b = 1'b0; wdata_b = 16'h0000;
        tick(); tick();
        for (int d = 0; d < 2; d++) begin
            nvec++;
            if ({gnt_a[d], gnt_b[d], done_a[d], done_b[d], mem_sel[d], mem_write[d]} !== 6'b000000) begin
                nerr++;
                $display("FAIL reset_ctrl dut%0d got %b%b%b%b%b%b want 000000", d,
                         gnt_a[d], gnt_b[d], done_a[d], done_b[d], mem_sel[d], mem_write[d]);
            end
            nvec++;
            if ({rdata_a[d], rdata_b[d], mem_din[d]} !== 48'h0) begin
                nerr++;
                $display("FAIL reset_data dut%0d got %h %h %h want 0", d, rdata_a[d], rdata_b[d], mem_din[d]);
            end
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_writes();
        int          port_t [2] = '{0, 1};
        logic        sel_t [2]  = '{1'b0, 1'b1};
        logic [15:0] dat_t [2]  = '{16'hA5A5, 16'h3C3C};
        logic [1:0]  oh;
        for (int v = 0; v < 2; v++) begin
            run_single(port_t[v], 1'b1, sel_t[v], dat_t[v]);
            oh = (port_t[v] == 0) ? 2'b01 : 2'b10;
            for (int d = 0; d < 2; d++) begin
                nvec++;
                if (obs_gnt[d] !== oh || obs_sel[d] !== sel_t[v]) begin
                    nerr++;
                    $display("FAIL wr_gnt v%0d dut%0d got gnt=%b sel=%b want gnt=%b sel=%b", v, d, obs_gnt[d], obs_sel[d], oh, sel_t[v]);
                end
                nvec++;
                if (obs_done[d] !== oh || obs_after[d] !== 2'b00) begin
                    nerr++;
                    $display("FAIL wr_done v%0d dut%0d got %b,%b want %b,00", v, d, obs_done[d], obs_after[d], oh);
                end
                nvec++;
                if (obs_mw[d] !== 1 || obs_rdata[d] !== dat_t[v]) begin
                    nerr++;
                    $display("FAIL wr_data v%0d dut%0d got mw=%0d rdata=%h want mw=1 rdata=%h", v, d, obs_mw[d], obs_rdata[d], dat_t[v]);
                end
            end
        end
    endtask

    task automatic test_readback();
        int          port_t [2] = '{0, 1};
        logic        sel_t [2]  = '{1'b0, 1'b1};
        logic [15:0] exp_t [2]  = '{16'hA5A5, 16'h3C3C};
        logic [1:0]  oh;
        for (int v = 0; v < 2; v++) begin
            run_single(port_t[v], 1'b0, sel_t[v], 16'hDEAD);
            oh = (port_t[v] == 0) ? 2'b01 : 2'b10;
            for (int d = 0; d < 2; d++) begin
                nvec++;
                if (obs_gnt[d] !== oh || obs_done[d] !== oh) begin
                    nerr++;
                    $display("FAIL rd_hs v%0d dut%0d got gnt=%b done=%b want %b", v, d, obs_gnt[d], obs_done[d], oh);
                end
                nvec++;
                if (obs_mw[d] !== 0 || obs_rdata[d] !== exp_t[v]) begin
                    nerr++;
                    $display("FAIL rd_data v%0d dut%0d got mw=%0d rdata=%h want mw=0 rdata=%h", v, d, obs_mw[d], obs_rdata[d], exp_t[v]);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [1:0] exp_rr [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [1:0] exp_g [2];
        req_a = 1'b1; we_a = 1'b0; sel_a = 1'b0;
        req_b = 1'b1; we_b = 1'b0; sel_b = 1'b1;
        for (int t = 0; t < 12; t++) begin
            tick();
            exp_g[0] = (t % 3 == 0) ? exp_rr[t / 3] : 2'b00;
            exp_g[1] = (t % 3 == 0) ? 2'b01 : 2'b00;
            for (int d = 0; d < 2; d++) begin
                nvec++;
                if ({gnt_b[d], gnt_a[d]} !== exp_g[d] || (done_a[d] & done_b[d]) !== 1'b0) begin
                    nerr++;
                    $display("FAIL both_req t%0d dut%0d got gnt=%b done=%b%b want gnt=%b", t, d,
                             {gnt_b[d], gnt_a[d]}, done_b[d], done_a[d], exp_g[d]);
                end
            end
        end
        req_a = 1'b0;
        tick();
        for (int d = 0; d < 2; d++) begin
            nvec++;
            if ({gnt_b[d], gnt_a[d]} !== 2'b10) begin
                nerr++;
                $display("FAIL drop_a dut%0d got gnt=%b want 10", d, {gnt_b[d], gnt_a[d]});
            end
        end
        req_b = 1'b0;
        tick(); tick();
    endtask

    task automatic test_hazard();
        run_single(1, 1'b1, 1'b1, 16'hFFFF);
        run_single(0, 1'b0, 1'b1, 16'h0000);
        for (int d = 0; d < 2; d++) begin
            nvec++;
            if (obs_rdata[d] !== 16'hFFFF || obs_done[d] !== 2'b01) begin
                nerr++;
                $display("FAIL hazard dut%0d got rdata=%h done=%b want rdata=ffff done=01", d, obs_rdata[d], obs_done[d]);
            end
        end
    endtask

    task automatic test_reset_mid();
        req_a = 1'b1; we_a = 1'b1; sel_a = 1'b0; wdata_a = 16'h1234;
        tick();
        req_a = 1'b0;
        rst_n = 1'b0;
        tick();
        for (int d = 0; d < 2; d++) begin
            nvec++;
            if ({gnt_a[d], gnt_b[d], done_a[d], done_b[d], mem_sel[d], mem_write[d]} !== 6'b000000 ||
                {rdata_a[d], rdata_b[d], mem_din[d]} !== 48'h0) begin
                nerr++;
                $display("FAIL mid_reset dut%0d got ctl=%b%b%b%b%b%b ra=%h rb=%h din=%h want 0", d,
                         gnt_a[d], gnt_b[d], done_a[d], done_b[d], mem_sel[d], mem_write[d],
                         rdata_a[d], rdata_b[d], mem_din[d]);
            end
        end
        rst_n = 1'b1;
        tick();
        for (int d = 0; d < 2; d++) begin
            nvec++;
            if ({done_a[d], done_b[d], gnt_a[d], gnt_b[d]} !== 4'b0000) begin
                nerr++;
                $display("FAIL post_reset dut%0d got done/gnt=%b%b%b%b want 0000", d, done_a[d], done_b[d], gnt_a[d], gnt_b[d]);
            end
        end
        run_single(0, 1'b0, 1'b0, 16'h0000);
        for (int d = 0; d < 2; d++) begin
            nvec++;
            if (obs_rdata[d] !== 16'h1234) begin
                nerr++;
                $display("FAIL reset_commit dut%0d got %h want 1234", d, obs_rdata[d]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_writes();
        test_readback();
        test_simultaneous();
        test_hazard();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
